mem_stage_ctrl: RTL and testbench

//  Consumer end of the execute-stage result interface: accepts one ALU result per handshake
//  (address or pass-through value plus store data and mem/reg controls).

---
 rtl/mem_stage_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: accepts one execute-stage result, sequences a multi-cycle data
// memory access (with stall/retry), and presents the writeback result on a valid/ready
// handshake. Synchronous active-high reset.
// Optional feature: define ALIGN_CHECK_EN to flag odd-address memory ops via err_o
// instead of issuing them; when undefined err_o is constant 0.
module mem_stage_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    // execute-stage result interface
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [15:0] ex_aluOut_i,
    input  logic [15:0] ex_wrData_i,
    input  logic        ex_memRead_i,
    input  logic        ex_memWrite_i,
    input  logic        ex_regWrite_i,
    input  logic [2:0]  ex_writeReg_i,
    // data memory interface
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_stall_i,
    input  logic        mem_done_i,
    input  logic [15:0] mem_rdata_i,
    // writeback interface
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [15:0] wb_data_o,
    output logic        wb_regWrite_o,
    output logic [2:0]  wb_writeReg_o,
    output logic        err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e      state_q;
    logic        mem_rd_q, mem_wr_q;
    logic [15:0] mem_addr_q, mem_wdata_q;
    logic        is_load_q;
    logic        regwrite_q;
    logic        wb_valid_q, wb_regWrite_q, err_q;
    logic [15:0] wb_data_q;
    logic [2:0]  wb_writeReg_q;

    logic accept, mem_op, is_store, is_load, misalign, complete;

    // Decode the incoming op and detect completion of the outstanding access
    always_comb begin
        accept   = ex_valid_i & ex_ready_o;
        is_store = ex_memWrite_i;                   // read+write together counts as a store
        is_load  = ex_memRead_i & ~ex_memWrite_i;
        mem_op   = ex_memRead_i | ex_memWrite_i;
`ifdef ALIGN_CHECK_EN
        misalign = ex_aluOut_i[0];
`else
        misalign = 1'b0;
`endif
        complete = ((state_q == StReq) & ~mem_stall_i & mem_done_i) |
                   ((state_q == StWait) & mem_done_i);
    end

    // Control FSM with registered memory and writeback outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= 16'h0;
            mem_wdata_q   <= 16'h0;
            is_load_q     <= 1'b0;
            regwrite_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_regWrite_q <= 1'b0;
            wb_data_q     <= 16'h0;
            wb_writeReg_q <= 3'h0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        wb_data_q     <= ex_aluOut_i;
                        wb_writeReg_q <= ex_writeReg_i;
                        is_load_q     <= is_load;
                        if (mem_op && misalign) begin
                            state_q       <= StResp;
                            wb_valid_q    <= 1'b1;
                            wb_regWrite_q <= 1'b0;
                            err_q         <= 1'b1;
                        end else if (mem_op) begin
                            state_q     <= StReq;
                            mem_rd_q    <= is_load;
                            mem_wr_q    <= is_store;
                            mem_addr_q  <= ex_aluOut_i;
                            mem_wdata_q <= ex_wrData_i;
                            regwrite_q  <= ex_regWrite_i & is_load;
                        end else begin
                            state_q       <= StResp;
                            wb_valid_q    <= 1'b1;
                            wb_regWrite_q <= ex_regWrite_i;
                        end
                    end
                end
                StReq: begin
                    // A stall keeps the request asserted unchanged for a retry
                    if (!mem_stall_i) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= StWait;
                    end
                end
                StWait: ;
                StResp: begin
                    if (wb_ready_i) begin
                        state_q       <= StIdle;
                        wb_valid_q    <= 1'b0;
                        wb_regWrite_q <= 1'b0;
                        err_q         <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Completion overrides the REQ->WAIT transition on a single-cycle hit
            if (complete) begin
                state_q       <= StResp;
                wb_valid_q    <= 1'b1;
                wb_regWrite_q <= regwrite_q;
                if (is_load_q) wb_data_q <= mem_rdata_i;
            end
        end
    end

    // Output drive
    always_comb begin
        ex_ready_o    = (state_q == StIdle) & ~rst_i;
        mem_rd_o      = mem_rd_q;
        mem_wr_o      = mem_wr_q;
        mem_addr_o    = mem_addr_q;
        mem_wdata_o   = mem_wdata_q;
        wb_valid_o    = wb_valid_q;
        wb_data_o     = wb_data_q;
        wb_regWrite_o = wb_regWrite_q;
        wb_writeReg_o = wb_writeReg_q;
        err_o         = err_q;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed stimulus pushes expected writeback results,
// a negedge monitor pops and compares on every wb handshake and tallies memory requests.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [15:0] ex_aluOut, ex_wrData;
    logic        ex_memRead, ex_memWrite, ex_regWrite;
    logic [2:0]  ex_writeReg;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_stall, mem_done;
    logic [15:0] mem_rdata;
    logic        wb_valid, wb_ready;
    logic [15:0] wb_data;
    logic        wb_regWrite;
    logic [2:0]  wb_writeReg;
    logic        err;

    mem_stage_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ex_valid_i    (ex_valid),
        .ex_ready_o    (ex_ready),
        .ex_aluOut_i   (ex_aluOut),
        .ex_wrData_i   (ex_wrData),
        .ex_memRead_i  (ex_memRead),
        .ex_memWrite_i (ex_memWrite),
        .ex_regWrite_i (ex_regWrite),
        .ex_writeReg_i (ex_writeReg),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_stall_i   (mem_stall),
        .mem_done_i    (mem_done),
        .mem_rdata_i   (mem_rdata),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_data_o     (wb_data),
        .wb_regWrite_o (wb_regWrite),
        .wb_writeReg_o (wb_writeReg),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        chk_data;
        logic        rw;
        logic [2:0]  wreg;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt, wr_cnt, rd_ok, wr_ok;
    logic [15:0] exp_addr, exp_wdata;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every writeback handshake and tally memory request cycles
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd) begin
                rd_cnt++;
                if (mem_addr == exp_addr) rd_ok++;
            end
            if (mem_wr) begin
                wr_cnt++;
                if (mem_addr == exp_addr && mem_wdata == exp_wdata) wr_ok++;
            end
            if (wb_valid && wb_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: got wb_data %h expected no result", wb_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.chk_data) check("wb_data", wb_data, e.data);
                    check("wb_regWrite", {15'h0, wb_regWrite}, {15'h0, e.rw});
                    check("wb_writeReg", {13'h0, wb_writeReg}, {13'h0, e.wreg});
                    check("err", {15'h0, err}, {15'h0, e.err});
                end
            end
        end
    end

    task automatic clr_cnt();
        rd_cnt = 0; wr_cnt = 0; rd_ok = 0; wr_ok = 0;
    endtask

    // Present one op for a single cycle; returns #1 into the cycle after acceptance
    task automatic issue(input logic [15:0] alu, input logic [15:0] wd, input logic rd,
                         input logic wr, input logic rw, input logic [2:0] wreg);
        @(posedge clk); #1;
        check("ex_ready_idle", {15'h0, ex_ready}, 16'h1);
        ex_valid = 1'b1; ex_aluOut = alu; ex_wrData = wd;
        ex_memRead = rd; ex_memWrite = wr; ex_regWrite = rw; ex_writeReg = wreg;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_aluOut = 16'h0; ex_wrData = 16'h0;
        ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_regWrite = 1'b0; ex_writeReg = 3'h0;
        mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0; wb_ready = 1'b1;
        exp_addr = 16'h0; exp_wdata = 16'h0;
        clr_cnt();

        // Reset state
        step(2);
        check("ex_ready_in_rst", {15'h0, ex_ready}, 16'h0);
        rst = 1'b0;
        #1;
        check("rst_wb_valid", {15'h0, wb_valid}, 16'h0);
        check("rst_mem_rd", {15'h0, mem_rd}, 16'h0);
        check("rst_mem_wr", {15'h0, mem_wr}, 16'h0);
        check("rst_wb_data", wb_data, 16'h0);
        check("rst_err", {15'h0, err}, 16'h0);

        // Non-memory op, latency 1
        clr_cnt();
        sb_q.push_back('{data: 16'h1234, chk_data: 1'b1, rw: 1'b1, wreg: 3'd3, err: 1'b0});
        issue(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3);
        check("add_wb_valid", {15'h0, wb_valid}, 16'h1);
        step(2);
        check("add_rd_cnt", rd_cnt[15:0], 16'd0);
        check("add_wr_cnt", wr_cnt[15:0], 16'd0);

        // Load, done 3 cycles after the request
        clr_cnt();
        exp_addr = 16'h0010;
        sb_q.push_back('{data: 16'hBEEF, chk_data: 1'b1, rw: 1'b1, wreg: 3'd1, err: 1'b0});
        issue(16'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1);
        step(3);
        mem_done = 1'b1; mem_rdata = 16'hBEEF;
        step(1);
        mem_done = 1'b0; mem_rdata = 16'h0;
        check("ld_wb_valid", {15'h0, wb_valid}, 16'h1);
        step(2);
        check("ld_rd_cnt", rd_cnt[15:0], 16'd1);
        check("ld_rd_addr_ok", rd_ok[15:0], 16'd1);
        check("ld_wr_cnt", wr_cnt[15:0], 16'd0);

        // Store with 2 stall cycles, done on the accepted request
        clr_cnt();
        exp_addr = 16'h0020; exp_wdata = 16'h00AA;
        sb_q.push_back('{data: 16'h0, chk_data: 1'b0, rw: 1'b0, wreg: 3'd2, err: 1'b0});
        issue(16'h0020, 16'h00AA, 1'b0, 1'b1, 1'b1, 3'd2);
        mem_stall = 1'b1;
        step(2);
        mem_stall = 1'b0; mem_done = 1'b1;
        step(1);
        mem_done = 1'b0;
        check("st_wb_valid", {15'h0, wb_valid}, 16'h1);
        step(2);
        check("st_wr_cnt", wr_cnt[15:0], 16'd3);
        check("st_wr_same", wr_ok[15:0], 16'd3);
        check("st_rd_cnt", rd_cnt[15:0], 16'd0);

        // Load completing while writeback is back-pressured
        clr_cnt();
        exp_addr = 16'h0030;
        wb_ready = 1'b0;
        sb_q.push_back('{data: 16'h5A5A, chk_data: 1'b1, rw: 1'b1, wreg: 3'd5, err: 1'b0});
        issue(16'h0030, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5);
        mem_done = 1'b1; mem_rdata = 16'h5A5A;
        step(1);
        mem_done = 1'b0; mem_rdata = 16'h0;
        for (int i = 0; i < 4; i++) begin
            check("bp_wb_valid", {15'h0, wb_valid}, 16'h1);
            check("bp_wb_data", wb_data, 16'h5A5A);
            check("bp_ex_ready", {15'h0, ex_ready}, 16'h0);
            step(1);
        end
        wb_ready = 1'b1;
        step(1);
        check("bp_retired", {15'h0, wb_valid}, 16'h0);
        check("bp_rd_cnt", rd_cnt[15:0], 16'd1);

        // mem_done while idle is ignored
        mem_done = 1'b1; mem_rdata = 16'h7777;
        step(1);
        mem_done = 1'b0;
        step(1);
        check("idle_done_no_wb", {15'h0, wb_valid}, 16'h0);

        // Reset during WAIT, then a late mem_done
        clr_cnt();
        exp_addr = 16'h0040;
        issue(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd6);
        step(1);
        check("wait_mem_rd", {15'h0, mem_rd}, 16'h0);
        rst = 1'b1;
        #1;
        check("abort_ex_ready", {15'h0, ex_ready}, 16'h0);
        step(1);
        rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD;
        step(1);
        mem_done = 1'b0;
        step(1);
        check("abort_wb_valid", {15'h0, wb_valid}, 16'h0);
        check("abort_mem_rd", {15'h0, mem_rd}, 16'h0);
        check("abort_mem_addr", mem_addr, 16'h0);
        check("abort_wb_data", wb_data, 16'h0);
        check("abort_ex_ready_idle", {15'h0, ex_ready}, 16'h1);

`ifdef ALIGN_CHECK_EN
        // Misaligned load: no request, error result next cycle
        clr_cnt();
        sb_q.push_back('{data: 16'h0011, chk_data: 1'b1, rw: 1'b0, wreg: 3'd4, err: 1'b1});
        issue(16'h0011, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4);
        check("mis_wb_valid", {15'h0, wb_valid}, 16'h1);
        check("mis_err", {15'h0, err}, 16'h1);
        step(2);
        check("mis_rd_cnt", rd_cnt[15:0], 16'd0);
`endif

        step(2);
        check("sb_drained", sb_q.size() > 0 ? 16'h1 : 16'h0, 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
